matrix_reader: RTL and testbench

//  Read-side client of matrix_storage: walks one stored matrix (m x n, slot 0/1) in row-major order.

---
 rtl/matrix_reader_pkg.sv | 24 ++
 rtl/matrix_reader_addr_walker.sv | 62 ++++++
 rtl/matrix_reader.sv | 178 +++++++++++++++++
 tb/tb_matrix_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_reader_pkg.sv
// Shared definitions for the matrix reader block.
// Holds default geometry constants, the request-field width, the reader FSM state encoding
// and a helper that checks a requested dimension against the legal range 1..max_dim.
package matrix_reader_pkg;

    localparam int unsigned DefMaxDim    = 5;
    localparam int unsigned DefElemWidth = 8;
    localparam int unsigned DefDimBits   = 3;
    localparam int unsigned ReqWidth     = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StWait  = 3'd2,
        StPush  = 3'd3,
        StFin   = 3'd4,
        StFail  = 3'd5
    } rd_state_e;

    function automatic logic dim_ok(input logic [ReqWidth-1:0] d, input int unsigned max_dim);
        return (d != '0) && (32'(d) <= max_dim);
    endfunction

endpackage

// File: rtl/matrix_reader_addr_walker.sv
// Row-major row/col counter for the matrix reader.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         zero both counters (takes priority over inc_i)
//   inc_i           advance one element; ignored on the last element
//   m_i, n_i        matrix dimensions (already range-checked by the caller)
//   row_o, col_o    current position
//   row_last_o      col_o == n_i-1
//   last_o          row_o == m_i-1 and col_o == n_i-1
module matrix_reader_addr_walker
    import matrix_reader_pkg::*;
#(
    parameter int unsigned DimBits = DefDimBits
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                inc_i,
    input  logic [ReqWidth-1:0] m_i,
    input  logic [ReqWidth-1:0] n_i,
    output logic [DimBits-1:0]  row_o,
    output logic [DimBits-1:0]  col_o,
    output logic                row_last_o,
    output logic                last_o
);

    logic [DimBits-1:0] row_q, row_d;
    logic [DimBits-1:0] col_q, col_d;

    always_comb begin
        row_last_o = (ReqWidth'(col_q) == (n_i - ReqWidth'(1)));
        last_o     = row_last_o && (ReqWidth'(row_q) == (m_i - ReqWidth'(1)));
        row_d      = row_q;
        col_d      = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i && !last_o) begin
            // Holding on the last element keeps the counters within m-1/n-1.
            if (row_last_o) begin
                col_d = '0;
                row_d = row_q + DimBits'(1);
            end else begin
                col_d = col_q + DimBits'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;

endmodule

// File: rtl/matrix_reader.sv
// Read-side client of matrix storage: walks one stored m x n matrix in row-major order,
// issuing one storage read per element and streaming each element to a consumer over
// valid/ready, tagged with row-end and matrix-end markers.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   start, req_m, req_n, req_slot  request (sampled only when idle)
//   busy                           transfer in progress (through the done cycle)
//   rd_en, rd_m, rd_n, rd_slot_idx, rd_row_idx, rd_col_idx   storage read interface
//   rd_elem, rd_elem_valid         storage return data
//   out_elem, out_valid, out_ready, out_row_last, out_last   element stream
//   done, err                      end-of-transfer pulse, err qualifies a failure
module matrix_reader
    import matrix_reader_pkg::*;
#(
    parameter int unsigned MaxDim    = DefMaxDim,
    parameter int unsigned ElemWidth = DefElemWidth,
    parameter int unsigned DimBits   = DefDimBits
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ReqWidth-1:0]  req_m,
    input  logic [ReqWidth-1:0]  req_n,
    input  logic                 req_slot,
    output logic                 busy,
    output logic                 rd_en,
    output logic [ReqWidth-1:0]  rd_m,
    output logic [ReqWidth-1:0]  rd_n,
    output logic                 rd_slot_idx,
    output logic [DimBits-1:0]   rd_row_idx,
    output logic [DimBits-1:0]   rd_col_idx,
    input  logic [ElemWidth-1:0] rd_elem,
    input  logic                 rd_elem_valid,
    output logic [ElemWidth-1:0] out_elem,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_row_last,
    output logic                 out_last,
    output logic                 done,
    output logic                 err
);

    rd_state_e            state_q, state_d;
    logic [ReqWidth-1:0]  m_q, m_d;
    logic [ReqWidth-1:0]  n_q, n_d;
    logic                 slot_q, slot_d;
    logic [ElemWidth-1:0] elem_q, elem_d;
    logic                 row_last_q, row_last_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 rd_en_q, rd_en_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 walk_clr, walk_inc;
    logic                 walk_row_last, walk_last;

    matrix_reader_addr_walker #(
        .DimBits (DimBits)
    ) u_walker (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clear_i    (walk_clr),
        .inc_i      (walk_inc),
        .m_i        (m_q),
        .n_i        (n_q),
        .row_o      (rd_row_idx),
        .col_o      (rd_col_idx),
        .row_last_o (walk_row_last),
        .last_o     (walk_last)
    );

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        n_d        = n_q;
        slot_d     = slot_q;
        elem_d     = elem_q;
        row_last_d = row_last_q;
        last_d     = last_q;
        walk_clr   = 1'b0;
        walk_inc   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d      = req_m;
                    n_d      = req_n;
                    slot_d   = req_slot;
                    walk_clr = 1'b1;
                    if (dim_ok(req_m, MaxDim) && dim_ok(req_n, MaxDim)) begin
                        state_d = StIssue;
                    end else begin
                        state_d = StFail;
                    end
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                // No valid pulse one cycle after the strobe means the slot holds no such matrix.
                if (rd_elem_valid) begin
                    elem_d     = rd_elem;
                    row_last_d = walk_row_last;
                    last_d     = walk_last;
                    state_d    = StPush;
                end else begin
                    state_d = StFail;
                end
            end
            StPush: begin
                if (out_ready) begin
                    row_last_d = 1'b0;
                    last_d     = 1'b0;
                    if (last_q) begin
                        state_d = StFin;
                    end else begin
                        walk_inc = 1'b1;
                        state_d  = StIssue;
                    end
                end
            end
            StFin:   state_d = StIdle;
            StFail:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered as a decode of the next state.
        busy_d  = (state_d != StIdle);
        rd_en_d = (state_d == StIssue);
        valid_d = (state_d == StPush);
        done_d  = (state_d == StFin) || (state_d == StFail);
        err_d   = (state_d == StFail);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            m_q        <= '0;
            n_q        <= '0;
            slot_q     <= 1'b0;
            elem_q     <= '0;
            row_last_q <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            n_q        <= n_d;
            slot_q     <= slot_d;
            elem_q     <= elem_d;
            row_last_q <= row_last_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            rd_en_q    <= rd_en_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy         = busy_q;
    assign rd_en        = rd_en_q;
    assign rd_m         = m_q;
    assign rd_n         = n_q;
    assign rd_slot_idx  = slot_q;
    assign out_elem     = elem_q;
    assign out_valid    = valid_q;
    assign out_row_last = row_last_q;
    assign out_last     = last_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_matrix_reader.sv
// Self-checking bench for matrix_reader with a behavioural storage model and a scoreboard.
module tb_matrix_reader;
    import matrix_reader_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] req_m, req_n;
    logic       req_slot;
    logic       busy, rd_en, rd_slot_idx;
    logic [3:0] rd_m, rd_n;
    logic [2:0] rd_row_idx, rd_col_idx;
    logic [7:0] rd_elem;
    logic       rd_elem_valid;
    logic [7:0] out_elem;
    logic       out_valid, out_ready, out_row_last, out_last, done, err;

    matrix_reader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .req_m         (req_m),
        .req_n         (req_n),
        .req_slot      (req_slot),
        .busy          (busy),
        .rd_en         (rd_en),
        .rd_m          (rd_m),
        .rd_n          (rd_n),
        .rd_slot_idx   (rd_slot_idx),
        .rd_row_idx    (rd_row_idx),
        .rd_col_idx    (rd_col_idx),
        .rd_elem       (rd_elem),
        .rd_elem_valid (rd_elem_valid),
        .out_elem      (out_elem),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_row_last  (out_row_last),
        .out_last      (out_last),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Storage model: answers a rising rd_en with a one-cycle valid pulse on the next cycle
    // when the slot holds a matrix of exactly the requested dimensions.
    logic [7:0]  mem [2][25];
    int unsigned st_m [2];
    int unsigned st_n [2];
    bit          st_ok [2] = '{1'b0, 1'b0};
    logic        rd_en_prev;
    int unsigned rd_cnt = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_prev    <= 1'b0;
            rd_elem_valid <= 1'b0;
            rd_elem       <= '0;
        end else begin
            rd_en_prev    <= rd_en;
            rd_elem_valid <= 1'b0;
            if (rd_en && !rd_en_prev) begin
                rd_cnt <= rd_cnt + 1;
                if (st_ok[rd_slot_idx] && st_m[rd_slot_idx] == 32'(rd_m)
                    && st_n[rd_slot_idx] == 32'(rd_n)) begin
                    rd_elem_valid <= 1'b1;
                    rd_elem <= mem[rd_slot_idx][int'(rd_row_idx) * 5 + int'(rd_col_idx)];
                end
            end
        end
    end

    typedef struct {
        logic [7:0] elem;
        logic       rl;
        logic       l;
    } beat_t;
    beat_t exp_q[$];
    int unsigned beats = 0;

    // Compare the presented beat against the scoreboard head every cycle it is valid, so a
    // stalled beat must stay stable; pop only when the handshake will complete.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", 32'(out_valid), 32'd0);
            end else begin
                check_eq("out_elem", 32'(out_elem), 32'(exp_q[0].elem));
                check_eq("out_row_last", 32'(out_row_last), 32'(exp_q[0].rl));
                check_eq("out_last", 32'(out_last), 32'(exp_q[0].l));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beats <= beats + 1;
                end
            end
        end
        if (rst && err) check_eq("err_without_done", 32'(done), 32'd1);
    end

    // Consumer: mode 0 always ready, mode 1 ready one cycle in three.
    int unsigned mode = 0;
    initial begin
        int unsigned ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 0) begin
                out_ready = 1'b1;
            end else begin
                out_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
        end
    end

    task automatic write_matrix(input int slot, input int m, input int n, input logic [7:0] base);
        for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++)
                mem[slot][r * 5 + c] = base + 8'(r * n + c);
        st_m[slot]  = m;
        st_n[slot]  = n;
        st_ok[slot] = 1'b1;
    endtask

    int unsigned start_cyc;
    int unsigned rd_start;

    task automatic do_start(input int m, input int n, input int slot, input bit exp_data);
        if (exp_data) begin
            for (int r = 0; r < m; r++)
                for (int c = 0; c < n; c++)
                    exp_q.push_back('{elem: mem[slot][r * 5 + c], rl: (c == n - 1),
                                      l: (r == m - 1) && (c == n - 1)});
        end
        @(posedge clk);
        #1;
        start     = 1'b1;
        req_m     = 4'(m);
        req_n     = 4'(n);
        req_slot  = 1'(slot);
        start_cyc = cyc;
        rd_start  = rd_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit exp_err, input int exp_lat, input int exp_rd);
        bit got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check_eq("done_seen", 32'(got), 32'd1);
        if (got) begin
            check_eq("err", 32'(err), 32'(exp_err));
            if (exp_lat >= 0) check_eq("done_latency", cyc - start_cyc, 32'(exp_lat));
            check_eq("busy_in_done", 32'(busy), 32'd1);
            @(negedge clk);
            check_eq("done_width", 32'(done), 32'd0);
            check_eq("busy_after_done", 32'(busy), 32'd0);
        end
        check_eq("rd_en_pulses", rd_cnt - rd_start, 32'(exp_rd));
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int unsigned b0;
        rst      = 1'b0;
        start    = 1'b0;
        req_m    = '0;
        req_n    = '0;
        req_slot = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd_en", 32'(rd_en), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_row_col", {26'd0, rd_row_idx, rd_col_idx}, 32'd0);
        rst = 1'b1;

        // 2x3 {1..6}, consumer always ready
        write_matrix(0, 2, 3, 8'd1);
        mode = 0;
        do_start(2, 3, 0, 1'b1);
        wait_done(1'b0, 19, 6);

        // Same matrix with a stalling consumer, plus a start while busy
        mode = 1;
        do_start(2, 3, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        start    = 1'b1;
        req_m    = 4'd1;
        req_n    = 4'd1;
        req_slot = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("latched_m", 32'(rd_m), 32'd2);
        check_eq("latched_n", 32'(rd_n), 32'd3);
        check_eq("latched_slot", 32'(rd_slot_idx), 32'd0);
        wait_done(1'b0, -1, 6);
        mode = 0;

        // Empty slot: one read, then failure
        do_start(4, 4, 1, 1'b0);
        wait_done(1'b1, 3, 1);

        // Out-of-range dimensions: fail without any read
        do_start(0, 3, 0, 1'b0);
        wait_done(1'b1, 1, 0);
        do_start(6, 2, 0, 1'b0);
        wait_done(1'b1, 1, 0);

        // 1x1
        write_matrix(1, 1, 1, 8'hA5);
        do_start(1, 1, 1, 1'b1);
        wait_done(1'b0, 4, 1);

        // Reset during a 5x5 transfer, then a fresh read from (0,0)
        write_matrix(1, 5, 5, 8'h10);
        do_start(5, 5, 1, 1'b1);
        b0 = beats;
        for (int i = 0; i < 200 && beats < b0 + 3; i++) @(negedge clk);
        check_eq("pre_reset_beats", beats - b0, 32'd3);
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        check_eq("push_before_reset", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_out_elem", 32'(out_elem), 32'd0);
        check_eq("arst_markers", {30'd0, out_row_last, out_last}, 32'd0);
        check_eq("arst_rd", {19'd0, rd_en, rd_m, rd_n, rd_slot_idx, rd_row_idx}, 32'd0);
        check_eq("arst_col", 32'(rd_col_idx), 32'd0);
        check_eq("arst_done_err", {30'd0, done, err}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_start(5, 5, 1, 1'b1);
        wait_done(1'b0, 76, 25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
